// File: rtl/rf_write_arbiter.sv
// Writeback arbiter: merges ALU and LSU results into the single register file
// write port with LSU priority, ALU anti-starvation, x0 suppression and a retire counter.
module rf_write_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [31:0]           wb_count
);

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned CNT_W  = 32;

    logic [WAIT_W-1:0]     alu_wait_q, alu_wait_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0]      wb_count_q, wb_count_d;
    logic                  starving;
    logic                  alu_fire;
    logic                  lsu_fire;

    // Readies depend only on the competing source and the starvation state.
    always_comb begin
        starving  = (alu_wait_q == WAIT_W'(STARVE_LIMIT));
        lsu_ready = !(alu_valid && starving);
        alu_ready = !lsu_valid || starving;
        lsu_fire  = lsu_valid && lsu_ready;
        alu_fire  = alu_valid && alu_ready;
    end

    // Next-state for the wait counter, output stage and retire counter.
    always_comb begin
        alu_wait_d = '0;
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        wb_count_d = wb_count_q;

        if (alu_valid && !alu_ready) begin
            alu_wait_d = starving ? alu_wait_q : alu_wait_q + WAIT_W'(1);
        end

        if (lsu_fire) begin
            rf_wen_d   = (lsu_rd != '0);
            rf_waddr_d = lsu_rd;
            rf_wdata_d = lsu_data;
            wb_count_d = wb_count_q + CNT_W'(1);
        end else if (alu_fire) begin
            rf_wen_d   = (alu_rd != '0);
            rf_waddr_d = alu_rd;
            rf_wdata_d = alu_data;
            wb_count_d = wb_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_wait_q <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            wb_count_q <= '0;
        end else begin
            alu_wait_q <= alu_wait_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign wb_count = wb_count_q;

endmodule
